// File: rtl/axis_video_stream_out.sv
// AXI4-Stream video to raster output stage: generic timing counters, registered
// pixel/sync outputs, and automatic resynchronisation after underflow or framing errors.
module axis_video_stream_out #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int BPC       = 8,
  parameter int TDATA_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TDATA_W-1:0] tdata,
  input  logic               tvalid,
  output logic               tready,
  input  logic               tuser,
  input  logic               tlast,
  output logic [BPC-1:0]     red,
  output logic [BPC-1:0]     green,
  output logic [BPC-1:0]     blue,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  input  logic               err_clr,
  output logic               underflow,
  output logic               sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  typedef enum logic {RESYNC, STREAM} state_t;

  state_t        state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active, origin, line_end, hs_on, vs_on;
  logic          show, to_resync, set_uf, set_se;

  assign active   = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  assign origin   = (h == '0) && (v == '0);
  assign line_end = (int'(h) == H_ACTIVE - 1);
  assign hs_on    = (int'(h) >= HS_BEG) && (int'(h) < HS_END);
  assign vs_on    = (int'(v) >= VS_BEG) && (int'(v) < VS_END);

  // A misplaced tuser beat is refused here so it can be replayed as pixel (0,0) later.
  always_comb begin
    tready    = 1'b0;
    show      = 1'b0;
    to_resync = 1'b0;
    set_uf    = 1'b0;
    set_se    = 1'b0;
    if (!rst) begin
      if (state == RESYNC) begin
        tready = ~tuser | origin;
        show   = tvalid & tuser & origin;
      end else begin
        tready = active & ~(tuser & ~origin);
        if (active) begin
          if (!tvalid) begin
            set_uf    = 1'b1;
            to_resync = 1'b1;
          end else if (tuser && !origin) begin
            set_se    = 1'b1;
            to_resync = 1'b1;
          end else begin
            show = 1'b1;
            if (tlast != line_end) begin
              set_se    = 1'b1;
              to_resync = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      state       <= RESYNC;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      blank       <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (int'(h) == H_TOTAL - 1) begin
        h <= '0;
        v <= (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (state == RESYNC && show) state <= STREAM;
      else if (to_resync)          state <= RESYNC;
      red         <= show ? tdata[BPC-1:0]       : '0;
      green       <= show ? tdata[2*BPC-1:BPC]   : '0;
      blue        <= show ? tdata[3*BPC-1:2*BPC] : '0;
      blank       <= ~show;
      hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= show & tuser & origin;
      // Setting a flag takes precedence over a simultaneous clear.
      underflow   <= set_uf | (underflow & ~err_clr);
      sync_err    <= set_se | (sync_err & ~err_clr);
    end
  end

  generate
    if (TDATA_W > 3 * BPC) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^tdata[TDATA_W-1:3*BPC];
    end
  endgenerate

endmodule

// File: tb/tb_axis_video_stream_out.sv
// Bench for axis_video_stream_out on a 14x7 raster: a per-cycle behavioural model
// derived from the frame rules, scripted scenarios and a randomized soak.
module tb_axis_video_stream_out;
  localparam int HA = 8, HT = 14, VA = 4, VT = 7, FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, err_clr = 1'b0;
  logic        tready;
  logic [7:0]  red, green, blue;
  logic        blank, hsync, vsync, frame_start, underflow, sync_err;

  always #5 clk = ~clk;

  axis_video_stream_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .BPC(8), .TDATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .tdata(tdata), .tvalid(tvalid), .tready(tready),
    .tuser(tuser), .tlast(tlast), .red(red), .green(green), .blue(blue),
    .blank(blank), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .err_clr(err_clr), .underflow(underflow), .sync_err(sync_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t q[$];
  int total = 0, bad = 0;

  // model: position of the cycle evaluated at the next posedge, sync state, flags
  int          m_t = 0;
  bit          m_sync = 1'b0, m_uf = 1'b0, m_se = 1'b0;
  logic [29:0] pend;
  bit          have_pend = 1'b0;
  int          fs_cnt = 0, held_cnt = 0;
  logic [7:0]  fs_red = '0, fs_green = '0;

  bit drop_en = 1'b0, rst_en = 1'b0, soak = 1'b0, clr_req = 1'b0, rst_req = 1'b1;
  int drop_t = 0, rst_t = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : model_p
    int h, v;
    bit act, org, show, uf, se;
    logic exp_rdy;
    logic [29:0] now;
    h = m_t % HT;
    v = m_t / HT;
    act = (h < HA) && (v < VA);
    org = (m_t == 0);
    show = 1'b0; uf = 1'b0; se = 1'b0; exp_rdy = 1'b0;
    if (!rst) begin
      if (!m_sync) begin
        exp_rdy = !tuser || org;
        show = tvalid && tuser && org;
      end else begin
        exp_rdy = act && !(tuser && !org);
        if (act) begin
          if (!tvalid) uf = 1'b1;
          else if (tuser && !org) se = 1'b1;
          else begin
            show = 1'b1;
            if (tlast != (h == HA - 1)) se = 1'b1;
          end
        end
      end
    end
    total++;
    if (tready !== exp_rdy) begin
      bad++;
      $display("FAIL tready t=%0t h=%0d v=%0d: got %b want %b", $time, h, v, tready, exp_rdy);
    end
    now = {red, green, blue, blank, hsync, vsync, frame_start, underflow, sync_err};
    if (have_pend) begin
      total++;
      if (now !== pend) begin
        bad++;
        $display("FAIL outputs t=%0t: got %h want %h", $time, now, pend);
      end
    end
    if (frame_start === 1'b1) begin
      fs_cnt++;
      fs_red = red;
      fs_green = green;
    end
    if (!rst && tvalid && tuser && !tready) held_cnt++;
    if (rst) begin
      pend = {24'h0, 3'b111, 3'b000};
      m_t = 0; m_sync = 1'b0; m_uf = 1'b0; m_se = 1'b0;
    end else begin
      m_uf = uf || (m_uf && !err_clr);
      m_se = se || (m_se && !err_clr);
      if (!m_sync) m_sync = show;
      else if (uf || se) m_sync = 1'b0;
      pend = {show ? tdata[7:0] : 8'h0, show ? tdata[15:8] : 8'h0, show ? tdata[23:16] : 8'h0,
              !show, !(h >= 10 && h < 12), !(v == 5), show && tuser && org, m_uf, m_se};
      m_t = (m_t + 1) % FT;
    end
    have_pend = 1'b1;
  end

  task automatic step();
    bit fire, r;
    @(negedge clk);
    fire = tvalid && tready;
    @(posedge clk);
    #1;
    if (fire && q.size() > 0) q.delete(0);
    r = rst_en && (m_t == rst_t);
    if (r) rst_en = 1'b0;
    rst = rst_req || r;
    err_clr = clr_req || (soak && $urandom_range(0, 99) < 4);
    if (q.size() > 0) begin
      tdata = q[0].data; tuser = q[0].user; tlast = q[0].last; tvalid = 1'b1;
    end else begin
      tdata = $urandom; tuser = 1'b0; tlast = 1'b0; tvalid = 1'b0;
    end
    if (drop_en && m_t == drop_t) begin
      tvalid = 1'b0;
      drop_en = 1'b0;
    end
    if (soak && $urandom_range(0, 99) < 2) tvalid = 1'b0;
  endtask

  task automatic push_frame(input int fid, input int bl_h, input int bl_v, input int keep);
    beat_t b;
    logic [3:0] f4;
    int n;
    f4 = 4'(fid);
    n = 0;
    for (int v = 0; v < VA; v++) begin
      for (int h = 0; h < HA; h++) begin
        if (keep < 0 || n < keep) begin
          b.data[31:24] = 8'($urandom);
          b.data[23:16] = 8'($urandom);
          b.data[15:8]  = {f4, 4'(v)};
          b.data[7:0]   = 8'(h);
          b.user = (h == 0 && v == 0);
          b.last = (h == HA - 1) ^ (h == bl_h && v == bl_v);
          if (soak && !(h == 0 && v == 0)) begin
            if ($urandom_range(0, 99) < 2) b.last = ~b.last;
            if ($urandom_range(0, 99) < 2) b.user = 1'b1;
          end
          q.push_back(b);
        end
        n++;
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (q.size() > 0 && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic wait_fs(input int maxc);
    int n = 0;
    while (fs_cnt == 0 && n < maxc) begin
      step();
      n++;
    end
    chk("fs_wait_timeout", int'(fs_cnt > 0), 1);
  endtask

  task automatic clear_flags();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
  endtask

  initial begin
    int hs_cnt, vs_cnt, bl_cnt, first_hs, first_vs, junk;
    beat_t b;
    // reset, then timing only with no stream
    repeat (3) step();
    rst_req = 1'b0;
    step();
    chk("reset_blank", int'(blank), 1);
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_vsync", int'(vsync), 1);
    hs_cnt = 0; vs_cnt = 0; bl_cnt = 0; first_hs = -1; first_vs = -1;
    for (int k = 1; k <= FT; k++) begin
      step();
      if (!hsync) begin hs_cnt++; if (first_hs < 0) first_hs = k; end
      if (!vsync) begin vs_cnt++; if (first_vs < 0) first_vs = k; end
      if (!blank) bl_cnt++;
    end
    chk("timing_hs_count", hs_cnt, 14);
    chk("timing_hs_first", first_hs, 11);
    chk("timing_vs_count", vs_cnt, 14);
    chk("timing_vs_first", first_vs, 71);
    chk("timing_blank_low", bl_cnt, 0);

    // source starts mid-frame with junk ahead of the first tuser
    repeat ($urandom_range(20, 60)) step();
    junk = $urandom_range(1, 6);
    for (int i = 0; i < junk; i++) begin
      b.data = $urandom; b.user = 1'b0; b.last = 1'($urandom);
      q.push_back(b);
    end
    fs_cnt = 0; held_cnt = 0;
    for (int f = 1; f <= 3; f++) push_frame(f, -1, -1, -1);
    drain(600);
    chk("start_held", int'(held_cnt > 0), 1);
    chk("start_fs_count", fs_cnt, 3);
    chk("start_last_fs", int'(fs_green), 8'h30);
    chk("start_uf", int'(underflow), 0);
    chk("start_se", int'(sync_err), 0);

    // tvalid dropped at (3,1)
    fs_cnt = 0;
    for (int f = 4; f <= 6; f++) push_frame(f, -1, -1, -1);
    wait_fs(200);
    drop_t = 1 * HT + 3;
    drop_en = 1'b1;
    drain(800);
    chk("drop_uf", int'(underflow), 1);
    chk("drop_fs_count", fs_cnt, 3);
    chk("drop_last_fs", int'(fs_green), 8'h60);

    // tlast at h=5, then tuser at h=2
    clear_flags();
    chk("clr_uf", int'(underflow), 0);
    fs_cnt = 0;
    push_frame(7, 5, 1, -1);
    push_frame(8, -1, -1, -1);
    drain(600);
    chk("tlast_se", int'(sync_err), 1);
    chk("tlast_fs_count", fs_cnt, 2);
    chk("tlast_last_fs", int'(fs_green), 8'h80);
    clear_flags();
    chk("clr_se1", int'(sync_err), 0);
    fs_cnt = 0;
    push_frame(9, -1, -1, 2);
    push_frame(10, -1, -1, -1);
    drain(600);
    chk("tuser_se", int'(sync_err), 1);
    chk("tuser_fs_count", fs_cnt, 2);
    chk("tuser_replay_green", int'(fs_green), 8'hA0);
    chk("tuser_replay_red", int'(fs_red), 0);
    clear_flags();
    chk("clr_se2", int'(sync_err), 0);

    // reset pulse at (4,2) while streaming
    fs_cnt = 0;
    for (int f = 11; f <= 13; f++) push_frame(f, -1, -1, -1);
    wait_fs(200);
    rst_t = 2 * HT + 4;
    rst_en = 1'b1;
    begin
      int n = 0;
      while (rst_en && n < 200) begin step(); n++; end
      chk("rst_wait_timeout", int'(rst_en), 0);
    end
    step();
    chk("midrst_blank", int'(blank), 1);
    chk("midrst_red", int'(red), 0);
    chk("midrst_fs", int'(frame_start), 0);
    drain(800);
    chk("midrst_fs_count", fs_cnt, 3);
    chk("midrst_last_fs", int'(fs_green), 8'hD0);
    chk("midrst_se", int'(sync_err), 0);

    // randomized soak: corrupted framing, random gaps and clears
    soak = 1'b1;
    for (int f = 14; f < 20; f++) push_frame(f, -1, -1, -1);
    drain(3000);
    soak = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
